// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared ALU control codes, FSM states and widths
package alu_share_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTL_W_DEF  = 4;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // On a tie the priority pointer decides; otherwise the lone requester wins.
    function automatic logic pick_grant(input logic v0, input logic v1, input logic ptr);
        if (v0 && v1) begin
            return ptr;
        end
        return v1;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// rtl/alu_share_arbiter_alu.sv - combinational ALU with zero flag; unknown codes give 0
module alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTL_W  = CTL_W_DEF
) (
    input  logic [CTL_W-1:0]  ctl,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] out,
    output logic              z
);

    always_comb begin
        out = '0;
        case (ctl)
            CTL_W'(ALU_AND): out = a & b;
            CTL_W'(ALU_OR):  out = a | b;
            CTL_W'(ALU_ADD): out = a + b;
            CTL_W'(ALU_SUB): out = a - b;
            CTL_W'(ALU_SLT): out = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            CTL_W'(ALU_NOR): out = ~(a | b);
            CTL_W'(ALU_XOR): out = a ^ b;
            default:         out = '0;
        endcase
    end

    assign z = (out == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between two requesters
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CTL_W   = CTL_W_DEF,
    parameter bit RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTL_W-1:0]  req0_ctl,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTL_W-1:0]  req1_ctl,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_out,
    output logic              rsp0_z,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_out,
    output logic              rsp1_z,
    output logic              busy
);

    state_t            state;
    logic              ptr;
    logic              grant;
    logic              next_grant;
    logic              any_valid;
    logic              idle;
    logic              rsp_take;
    logic [CTL_W-1:0]  ctl_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] result_q;
    logic              z_q;
    logic [DATA_W-1:0] alu_out;
    logic              alu_z;

    assign idle       = (state == ST_IDLE);
    assign any_valid  = req0_valid | req1_valid;
    assign next_grant = pick_grant(req0_valid, req1_valid, ptr);

    // Gated by rst_n so both readies drop the instant reset asserts.
    assign req0_ready = rst_n & idle & any_valid & ~next_grant;
    assign req1_ready = rst_n & idle & any_valid & next_grant;

    assign rsp_take   = grant ? rsp1_ready : rsp0_ready;

    assign rsp0_out   = result_q;
    assign rsp1_out   = result_q;
    assign rsp0_z     = z_q;
    assign rsp1_z     = z_q;

    alu #(
        .DATA_W (DATA_W),
        .CTL_W  (CTL_W)
    ) u_alu (
        .ctl (ctl_q),
        .a   (a_q),
        .b   (b_q),
        .out (alu_out),
        .z   (alu_z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= RR_INIT;
            grant      <= 1'b0;
            ctl_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            z_q        <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant <= next_grant;
                        ctl_q <= next_grant ? req1_ctl : req0_ctl;
                        a_q   <= next_grant ? req1_a   : req0_a;
                        b_q   <= next_grant ? req1_b   : req0_b;
                        busy  <= 1'b1;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q   <= alu_out;
                    z_q        <= alu_z;
                    rsp0_valid <= ~grant;
                    rsp1_valid <= grant;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_take) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                        ptr        <= ~grant;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scenario and randomized checks of alu_share_arbiter
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_ctl, req1_ctl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_out, rsp1_out;
    logic        rsp0_z, rsp1_z;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    alu_share_arbiter #(.DATA_W(32), .CTL_W(4), .RR_INIT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_ctl   (req0_ctl),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_ctl   (req1_ctl),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_out   (rsp0_out),
        .rsp0_z     (rsp0_z),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_out   (rsp1_out),
        .rsp1_z     (rsp1_z),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        case (ctl)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            4'b1101: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] rand_ctl();
        logic [3:0] tbl [9] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'hD, 4'h5, 4'hF};
        return tbl[$urandom_range(0, 8)];
    endfunction

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'($urandom_range(0, 15));
            2:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic clear_inputs;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_ctl = 0; req0_a = 0; req0_b = 0;
        req1_ctl = 0; req1_a = 0; req1_b = 0;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // Drives one op on requester r, returns result, latency from accept, and ok=0 on timeout.
    task automatic do_op(input int r, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] out, output logic z, output int lat, output bit ok);
        ok = 0; lat = 0; out = 0; z = 0;
        @(negedge clk);
        if (r == 0) begin req0_valid = 1; req0_ctl = ctl; req0_a = a; req0_b = b; end
        else        begin req1_valid = 1; req1_ctl = ctl; req1_a = a; req1_b = b; end
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((r == 0) ? req0_ready : req1_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        if (!ok) return;
        ok = 0;
        for (int i = 1; i < 20; i++) begin
            #1;
            if ((r == 0) ? rsp0_valid : rsp1_valid) begin
                lat = i; ok = 1;
                out = (r == 0) ? rsp0_out : rsp1_out;
                z   = (r == 0) ? rsp0_z : rsp1_z;
                break;
            end
            @(negedge clk);
        end
        if (r == 0) rsp0_ready = 1; else rsp1_ready = 1;
        @(negedge clk);
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        req0_valid = 1;
        #1;
        checks++;
        if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        end
        checks++;
        if (rsp0_out !== 32'd0 || rsp0_z !== 1'b1 || rsp1_out !== 32'd0 || rsp1_z !== 1'b1) begin
            failures++;
            $display("FAIL reset_result got=%h/%b exp=00000000/1", rsp0_out, rsp0_z);
        end
        @(negedge clk);
        req0_valid = 0;
        rst_n = 1;
        #1;
        checks++;
        if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 5'b0) begin
            failures++;
            $display("FAIL post_reset_idle got=%b exp=00000", {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        end
    endtask

    task automatic test_single_ops;
        logic [31:0] out;
        logic        z;
        int          lat;
        bit          ok;
        logic [3:0]  c;
        logic [31:0] a, b;
        do_op(0, 4'b0010, 32'd5, 32'd7, out, z, lat, ok);
        checks++;
        if (!ok || lat != 2 || out !== 32'd12 || z !== 1'b0) begin
            failures++;
            $display("FAIL add_5_7 got=ok%0d lat%0d %h z%b exp=ok1 lat2 0000000c z0", ok, lat, out, z);
        end
        do_op(0, 4'b0101, 32'd9, 32'd4, out, z, lat, ok);
        checks++;
        if (!ok || out !== 32'd0 || z !== 1'b1) begin
            failures++;
            $display("FAIL undef_ctl got=ok%0d %h z%b exp=ok1 00000000 z1", ok, out, z);
        end
        do_op(1, 4'b0111, 32'hFFFF_FFFF, 32'd1, out, z, lat, ok);
        checks++;
        if (!ok || out !== 32'd1 || z !== 1'b0) begin
            failures++;
            $display("FAIL slt_signed got=ok%0d %h z%b exp=ok1 00000001 z0", ok, out, z);
        end
        for (int i = 0; i < 6; i++) begin
            c = rand_ctl(); a = rand_data(); b = (i % 3 == 0) ? a : rand_data();
            do_op(i % 2, c, a, b, out, z, lat, ok);
            checks++;
            if (!ok || lat != 2 || out !== alu_ref(c, a, b) || z !== (alu_ref(c, a, b) == 32'd0)) begin
                failures++;
                $display("FAIL single_rand r%0d ctl=%h got=%h z%b lat%0d exp=%h", i % 2, c, out, z, lat, alu_ref(c, a, b));
            end
        end
    endtask

    task automatic test_tie_after_reset;
        apply_reset();
        @(negedge clk);
        req0_valid = 1; req0_ctl = 4'b0110; req0_a = 32'd3;    req0_b = 32'd3;
        req1_valid = 1; req1_ctl = 4'b0001; req1_a = 32'hF0;   req1_b = 32'h0F;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL tie_first_grant got=%b exp=10", {req0_ready, req1_ready});
        end
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_out !== 32'd0 || rsp0_z !== 1'b1) begin
            failures++;
            $display("FAIL tie_rsp0 got=v%b%b %h z%b exp=v10 00000000 z1", rsp0_valid, rsp1_valid, rsp0_out, rsp0_z);
        end
        rsp0_ready = 1;
        @(negedge clk);
        rsp0_ready = 0;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            failures++;
            $display("FAIL tie_second_grant got=%b exp=1", req1_ready);
        end
        @(negedge clk);
        req1_valid = 0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_out !== 32'hFF || rsp1_z !== 1'b0) begin
            failures++;
            $display("FAIL tie_rsp1 got=v%b%b %h z%b exp=v01 000000ff z0", rsp0_valid, rsp1_valid, rsp1_out, rsp1_z);
        end
        rsp1_ready = 1;
        @(negedge clk);
        rsp1_ready = 0;
    endtask

    // Both requesters continuously valid; pointer is 0 here so grants must alternate from 0.
    task automatic test_alternate;
        int          grants[$];
        int          served = 0;
        logic [31:0] exp_out = 0;
        bit          acc0 = 0, acc1 = 0;
        @(negedge clk);
        req0_valid = 1; req0_ctl = rand_ctl(); req0_a = rand_data(); req0_b = rand_data();
        req1_valid = 1; req1_ctl = rand_ctl(); req1_a = rand_data(); req1_b = rand_data();
        rsp0_ready = 1; rsp1_ready = 1;
        for (int c = 0; c < 60 && served < 4; c++) begin
            if (c != 0) @(negedge clk);
            if (acc0) begin req0_ctl = rand_ctl(); req0_a = rand_data(); req0_b = rand_data(); end
            if (acc1) begin req1_ctl = rand_ctl(); req1_a = rand_data(); req1_b = rand_data(); end
            acc0 = 0; acc1 = 0;
            #1;
            if (req0_ready) begin grants.push_back(0); exp_out = alu_ref(req0_ctl, req0_a, req0_b); acc0 = 1; end
            if (req1_ready) begin grants.push_back(1); exp_out = alu_ref(req1_ctl, req1_a, req1_b); acc1 = 1; end
            if (rsp0_valid || rsp1_valid) begin
                served++;
                checks++;
                if (rsp0_out !== exp_out) begin
                    failures++;
                    $display("FAIL alt_result op%0d got=%h exp=%h", served, rsp0_out, exp_out);
                end
            end
        end
        @(negedge clk);
        clear_inputs();
        checks++;
        if (grants.size() < 4) begin
            failures++;
            $display("FAIL alt_count got=%0d exp=4", grants.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grants[i] != (i % 2)) begin
                    failures++;
                    $display("FAIL alt_order idx%0d got=%0d exp=%0d", i, grants[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_stall;
        @(negedge clk);
        req1_valid = 1; req1_ctl = 4'b1101; req1_a = 32'hAAAA0000; req1_b = 32'hFFFF0000;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_accept got=%b exp=1", req1_ready);
        end
        @(negedge clk);
        req1_valid = 0;
        req0_valid = 1; req0_ctl = 4'b0010; req0_a = 32'd1; req0_b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({rsp1_valid, rsp0_valid, req0_ready, req1_ready, busy} !== 5'b10001 || rsp1_out !== 32'h55550000) begin
                failures++;
                $display("FAIL stall_hold cyc%0d got=%b %h exp=10001 55550000", i,
                         {rsp1_valid, rsp0_valid, req0_ready, req1_ready, busy}, rsp1_out);
            end
        end
        rsp1_ready = 1;
        @(negedge clk);
        rsp1_ready = 0;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got=%b exp=1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_out !== 32'd2) begin
            failures++;
            $display("FAIL stall_followup got=v%b %h exp=v1 00000002", rsp0_valid, rsp0_out);
        end
        rsp0_ready = 1;
        @(negedge clk);
        rsp0_ready = 0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req0_valid = 1; req0_ctl = 4'b0010; req0_a = 32'd10; req0_b = 32'd20;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_accept got=%b exp=1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 1; req1_ctl = 4'b0001; req1_a = 32'd3; req1_b = 32'd4;
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 5'b0) begin
            failures++;
            $display("FAIL mid_reset_async got=%b exp=00000", {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || rsp0_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_first_idle got=rdy%b v0%b exp=rdy1 v00", req1_ready, rsp0_valid);
        end
        @(negedge clk);
        req1_valid = 0;
        #1;
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_exec got=v%b%b exp=v00", rsp0_valid, rsp1_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b1 || rsp1_out !== 32'd7) begin
            failures++;
            $display("FAIL mid_new_rsp got=v%b%b %h exp=v01 00000007", rsp0_valid, rsp1_valid, rsp1_out);
        end
        rsp1_ready = 1;
        @(negedge clk);
        rsp1_ready = 0;
    endtask

    // Transaction-level model: at most one op outstanding, result due two cycles after acceptance.
    task automatic test_random;
        bit          pend = 0;
        int          pg = 0, start = 0, g;
        logic        ptr_m = 1'b0;
        logic [31:0] pres = 0;
        logic [4:0]  exp_flags;
        bit          acc0 = 0, acc1 = 0;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (acc0) req0_valid = 0;
            if (acc1) req1_valid = 0;
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1; req0_ctl = rand_ctl(); req0_a = rand_data();
                req0_b = ($urandom_range(0, 3) == 0) ? req0_a : rand_data();
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1; req1_ctl = rand_ctl(); req1_a = rand_data();
                req1_b = ($urandom_range(0, 3) == 0) ? req1_a : rand_data();
            end
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
            #1;
            acc0 = req0_ready; acc1 = req1_ready;
            if (!pend) begin
                g = -1;
                if (req0_valid && req1_valid) g = int'(ptr_m);
                else if (req0_valid)          g = 0;
                else if (req1_valid)          g = 1;
                exp_flags = {1'b0, g == 0, g == 1, 2'b00};
                if (g >= 0) begin
                    pend = 1; pg = g; start = c;
                    pres = (g == 0) ? alu_ref(req0_ctl, req0_a, req0_b) : alu_ref(req1_ctl, req1_a, req1_b);
                end
            end else if (c == start + 1) begin
                exp_flags = 5'b10000;
            end else begin
                exp_flags = {3'b100, pg == 0, pg == 1};
                checks++;
                if (rsp0_out !== pres || rsp0_z !== (pres == 32'd0)) begin
                    failures++;
                    $display("FAIL rand_result cyc%0d got=%h z%b exp=%h", c, rsp0_out, rsp0_z, pres);
                end
                if ((pg == 0) ? rsp0_ready : rsp1_ready) begin
                    pend = 0;
                    ptr_m = (pg == 0);
                end
            end
            checks++;
            if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== exp_flags) begin
                failures++;
                $display("FAIL rand_flags cyc%0d got=%b exp=%b", c,
                         {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid}, exp_flags);
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_single_ops();
        test_tie_after_reset();
        test_alternate();
        test_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
